// File: rtl/rom_access_arbiter_pkg.sv
// Shared definitions for the image ROM arbiter: default geometry, pixel count
// and the owner tag encoding carried down the access pipeline.
package rom_access_arbiter_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int PIX_COUNT = 307200;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  // Stage-1 tag: who issued the access and whether it was out of range
  typedef struct packed {
    owner_e owner;
    logic   oor;
  } tag_t;

endpackage

// File: rtl/rom_access_arbiter_pixel_addr_calc.sv
// Combinational (x, y) to linear ROM address for a 640-wide frame, with an
// out-of-range flag. Kept separate so the sprite ROM path can reuse it.
module pixel_addr_calc
  import rom_access_arbiter_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 19
) (
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              oor
);

  logic [ADDR_W-1:0] y_wide;
  logic [ADDR_W-1:0] x_wide;

  assign y_wide = ADDR_W'(y);
  assign x_wide = ADDR_W'(x);

  // y*640 as two shifts; 511*640+1023 still fits in 19 bits
  assign addr = (y_wide << 9) + (y_wide << 7) + x_wide;
  assign oor  = (x >= 10'(H_RES)) || (y >= 9'(V_RES));

endmodule

// File: rtl/rom_access_arbiter.sv
// Two-requester arbiter for the combinational image ROM: VGA scanout has fixed
// priority, the aux engine uses req/gnt. Optional macro ROM_ARB_STARVE_CNT_EN.
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int                H_RES     = H_RES_DEF,
  parameter int                V_RES     = V_RES_DEF,
  parameter int                ADDR_W    = 19,
  parameter int                DATA_W    = 12,
  parameter logic [DATA_W-1:0] OOR_COLOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [9:0]        vga_x,
  input  logic [8:0]        vga_y,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_data,
  output logic              aux_valid,
  output logic              aux_err,
`ifdef ROM_ARB_STARVE_CNT_EN
  output logic [15:0]       aux_starve_cnt,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(H_RES * V_RES);

  logic [ADDR_W-1:0] vga_addr;
  logic              vga_oor;
  logic              aux_oor;

  owner_e            owner_c;
  logic [ADDR_W-1:0] req_addr;
  logic              req_oor;
  logic              gnt_c;
  tag_t              tag_s1;

  pixel_addr_calc #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_addr_calc (
    .x   (vga_x),
    .y   (vga_y),
    .addr(vga_addr),
    .oor (vga_oor)
  );

  assign aux_oor = (aux_addr >= PIX_LIMIT);

  // Cycle-0 arbitration; nothing is granted while reset is held
  always_comb begin
    owner_c  = OWN_NONE;
    req_addr = rom_addr;
    req_oor  = 1'b0;
    gnt_c    = 1'b0;
    if (!rst) begin
      if (vga_req) begin
        owner_c  = OWN_VGA;
        req_addr = vga_addr;
        req_oor  = vga_oor;
      end else if (aux_req) begin
        owner_c  = OWN_AUX;
        req_addr = aux_addr;
        req_oor  = aux_oor;
        gnt_c    = 1'b1;
      end
    end
  end

  assign aux_gnt = gnt_c;

  // Stage 1 registers the address and tag; stage 2 steers the ROM word
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      tag_s1    <= '{owner: OWN_NONE, oor: 1'b0};
      vga_data  <= '0;
      vga_valid <= 1'b0;
      aux_data  <= '0;
      aux_valid <= 1'b0;
      aux_err   <= 1'b0;
    end else begin
      tag_s1 <= '{owner: owner_c, oor: req_oor};
      if ((owner_c != OWN_NONE) && !req_oor) begin
        rom_addr <= req_addr;
      end

      vga_valid <= 1'b0;
      aux_valid <= 1'b0;
      aux_err   <= 1'b0;
      case (tag_s1.owner)
        OWN_VGA: begin
          vga_data  <= tag_s1.oor ? OOR_COLOR : rom_data;
          vga_valid <= 1'b1;
        end
        OWN_AUX: begin
          aux_data  <= tag_s1.oor ? OOR_COLOR : rom_data;
          aux_valid <= 1'b1;
          aux_err   <= tag_s1.oor;
        end
        default: ;
      endcase
    end
  end

`ifdef ROM_ARB_STARVE_CNT_EN
  // Cycles the aux engine has waited with its request blocked by VGA
  always_ff @(posedge clk) begin
    if (rst || gnt_c) begin
      aux_starve_cnt <= '0;
    end else if (aux_req && (aux_starve_cnt != 16'hFFFF)) begin
      aux_starve_cnt <= aux_starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed, table-driven bench for rom_access_arbiter with a behavioural ROM;
// build with ROM_ARB_STARVE_CNT_EN to also cover the starvation counter.
module tb_rom_access_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;

  logic              clk;
  logic              rst;
  logic              vga_req;
  logic [9:0]        vga_x;
  logic [8:0]        vga_y;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              aux_req;
  logic [ADDR_W-1:0] aux_addr;
  logic              aux_gnt;
  logic [DATA_W-1:0] aux_data;
  logic              aux_valid;
  logic              aux_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
`ifdef ROM_ARB_STARVE_CNT_EN
  logic [15:0]       aux_starve_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  rom_access_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .vga_req  (vga_req),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .vga_data (vga_data),
    .vga_valid(vga_valid),
    .aux_req  (aux_req),
    .aux_addr (aux_addr),
    .aux_gnt  (aux_gnt),
    .aux_data (aux_data),
    .aux_valid(aux_valid),
    .aux_err  (aux_err),
`ifdef ROM_ARB_STARVE_CNT_EN
    .aux_starve_cnt(aux_starve_cnt),
`endif
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM contents: ROM[0] is 12'hABC, the rest a scrambled pattern
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    if (a == '0) return 12'hABC;
    return a[11:0] ^ {5'b0, a[18:12]} ^ 12'h3C3;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  typedef struct {
    logic              rst;
    logic              vreq;
    logic [9:0]        x;
    logic [8:0]        y;
    logic              areq;
    logic [ADDR_W-1:0] aaddr;
    logic              exp_vv;
    logic [DATA_W-1:0] exp_vd;
    logic              exp_gnt;
    logic              exp_av;
    logic [DATA_W-1:0] exp_ad;
    logic              exp_aerr;
    logic [ADDR_W-1:0] exp_raddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic vr, input int x, input int y,
                              input logic ar, input int aa, input logic vv,
                              input logic [DATA_W-1:0] vd, input logic g, input logic av,
                              input logic [DATA_W-1:0] ad, input logic ae, input int ra);
    vec_t v;
    v.rst = r; v.vreq = vr; v.x = 10'(x); v.y = 9'(y); v.areq = ar; v.aaddr = ADDR_W'(aa);
    v.exp_vv = vv; v.exp_vd = vd; v.exp_gnt = g; v.exp_av = av; v.exp_ad = ad;
    v.exp_aerr = ae; v.exp_raddr = ADDR_W'(ra);
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic vr, input int x, input int y,
                               input logic ar, input int aa);
    @(negedge clk);
    rst      = r;
    vga_req  = vr;
    vga_x    = 10'(x);
    vga_y    = 9'(y);
    aux_req  = ar;
    aux_addr = ADDR_W'(aa);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  vec_t vecs[14];

  initial begin
    rst = 1'b1; vga_req = 1'b0; vga_x = '0; vga_y = '0; aux_req = 1'b0; aux_addr = '0;

    //              rst vr  x    y   ar  aaddr   vv vd                 g  av ad            ae raddr
    vecs[0]  = mk(1, 0,   0,   0, 0,      0, 0, 12'h000,           0, 0, 12'h000,      0, 0);
    vecs[1]  = mk(1, 1,   5,   5, 1,     50, 0, 12'h000,           0, 0, 12'h000,      0, 0);
    vecs[2]  = mk(0, 1,   0,   0, 0,      0, 0, 12'h000,           0, 0, 12'h000,      0, 0);
    vecs[3]  = mk(0, 0,   0,   0, 0,      0, 0, 12'h000,           0, 0, 12'h000,      0, 0);
    vecs[4]  = mk(0, 1, 639, 479, 0,      0, 1, 12'hABC,           0, 0, 12'h000,      0, 0);
    vecs[5]  = mk(0, 1, 640,  10, 0,      0, 0, 12'hABC,           0, 0, 12'h000,      0, 307199);
    vecs[6]  = mk(0, 0,   0,   0, 0,      0, 1, rom_fn(19'd307199), 0, 0, 12'h000,     0, 307199);
    vecs[7]  = mk(0, 0,   0,   0, 1,    100, 1, 12'h000,           1, 0, 12'h000,      0, 307199);
    vecs[8]  = mk(0, 0,   0,   0, 1, 307200, 0, 12'h000,           1, 0, 12'h000,      0, 100);
    vecs[9]  = mk(0, 1,   3,   1, 1,    200, 0, 12'h000,           0, 1, rom_fn(19'd100), 0, 100);
    vecs[10] = mk(0, 0,   0,   0, 1,    200, 0, 12'h000,           1, 1, 12'h000,      1, 643);
    vecs[11] = mk(0, 0,   0,   0, 0,      0, 1, rom_fn(19'd643),   0, 0, 12'h000,      0, 200);
    vecs[12] = mk(0, 0,   0,   0, 0,      0, 0, rom_fn(19'd643),   0, 1, rom_fn(19'd200), 0, 200);
    vecs[13] = mk(0, 0,   0,   0, 0,      0, 0, rom_fn(19'd643),   0, 0, rom_fn(19'd200), 0, 200);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vreq, int'(vecs[i].x), int'(vecs[i].y),
                    vecs[i].areq, int'(vecs[i].aaddr));
      checkOutput($sformatf("v%0d.vga_valid", i), 32'(vga_valid), 32'(vecs[i].exp_vv));
      checkOutput($sformatf("v%0d.vga_data", i),  32'(vga_data),  32'(vecs[i].exp_vd));
      checkOutput($sformatf("v%0d.aux_gnt", i),   32'(aux_gnt),   32'(vecs[i].exp_gnt));
      checkOutput($sformatf("v%0d.aux_valid", i), 32'(aux_valid), 32'(vecs[i].exp_av));
      checkOutput($sformatf("v%0d.aux_data", i),  32'(aux_data),  32'(vecs[i].exp_ad));
      checkOutput($sformatf("v%0d.aux_err", i),   32'(aux_err),   32'(vecs[i].exp_aerr));
      checkOutput($sformatf("v%0d.rom_addr", i),  32'(rom_addr),  32'(vecs[i].exp_raddr));
    end

    // Contention: VGA holds the slot for 3 cycles, aux waits, then is granted once
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 1, c, 0, 1, 100);
      checkOutput($sformatf("contend%0d.aux_gnt", c), 32'(aux_gnt), 32'd0);
`ifdef ROM_ARB_STARVE_CNT_EN
      checkOutput($sformatf("contend%0d.starve", c), 32'(aux_starve_cnt), c);
`endif
    end
    checkOutput("contend2.vga_valid", 32'(vga_valid), 32'd1);
    checkOutput("contend2.vga_data", 32'(vga_data), 32'(rom_fn(19'd0)));
    applyStimulus(0, 0, 0, 0, 1, 100);
    checkOutput("contend3.aux_gnt", 32'(aux_gnt), 32'd1);
`ifdef ROM_ARB_STARVE_CNT_EN
    checkOutput("contend3.starve", 32'(aux_starve_cnt), 32'd3);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("contend4.aux_gnt", 32'(aux_gnt), 32'd0);
    checkOutput("contend4.aux_valid", 32'(aux_valid), 32'd0);
`ifdef ROM_ARB_STARVE_CNT_EN
    checkOutput("contend4.starve", 32'(aux_starve_cnt), 32'd0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("contend5.aux_valid", 32'(aux_valid), 32'd1);
    checkOutput("contend5.aux_data", 32'(aux_data), 32'(rom_fn(19'd100)));
    checkOutput("contend5.vga_valid", 32'(vga_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("contend6.aux_valid", 32'(aux_valid), 32'd0);

    // Streaming: x = 0..9 back to back gives ten consecutive in-order valids
    for (int k = 0; k < 12; k++) begin
      if (k < 10) applyStimulus(0, 1, k, 0, 0, 0);
      else        applyStimulus(0, 0, 0, 0, 0, 0);
      if (k >= 2) begin
        checkOutput($sformatf("stream%0d.vga_valid", k), 32'(vga_valid), 32'd1);
        checkOutput($sformatf("stream%0d.vga_data", k), 32'(vga_data), 32'(rom_fn(ADDR_W'(k - 2))));
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stream_end.vga_valid", 32'(vga_valid), 32'd0);

    // Reset the cycle after a VGA request: the in-flight access must vanish
    applyStimulus(0, 1, 7, 2, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rstmid1.rom_addr", 32'(rom_addr), 32'd1287);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rstmid2.vga_valid", 32'(vga_valid), 32'd0);
    checkOutput("rstmid2.vga_data", 32'(vga_data), 32'd0);
    checkOutput("rstmid2.aux_data", 32'(aux_data), 32'd0);
    checkOutput("rstmid2.rom_addr", 32'(rom_addr), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rstmid3.vga_valid", 32'(vga_valid), 32'd0);
    checkOutput("rstmid3.aux_valid", 32'(aux_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Sequences and shares the single combinational-read 640x480x12 image ROM between two requesters.
- Requester 1 is VGA scanout, which has fixed priority and is addressed by (x, y).
- Requester 2 is an auxiliary engine (screen-swap/fade logic), which is addressed by a linear address and uses a req/gnt handshake.
- Sits between the VGA timing/pixel path and the image ROM instance. The block owns rom_addr, computes linear addresses and registers returned data.

Parameters:
- H_RES, 640, horizontal pixels; row stride for address computation.
- V_RES, 480, vertical lines.
- ADDR_W, 19, ROM address width.
- DATA_W, 12, RGB444 pixel width.
- OOR_COLOR, 12'h000, data returned for out-of-range requests.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- vga_req  in  1  VGA fetch request for this cycle.
- vga_x  in  10  pixel column.
- vga_y  in  9  pixel row.
- vga_data  out  DATA_W  returned pixel.
- vga_valid  out  1  vga_data valid, one-cycle pulse.
- aux_req  in  1  aux request, level; held until granted.
- aux_addr  in  ADDR_W  aux linear address; stable while aux_req=1.
- aux_gnt  out  1  one-cycle grant pulse.
- aux_data  out  DATA_W  returned word.
- aux_valid  out  1  aux_data valid, one-cycle pulse.
- aux_err  out  1  pulses with aux_valid when aux_addr >= H_RES*V_RES.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_data  in  DATA_W  combinational ROM output.

Behaviour:
- Reset values: all outputs 0, owner tag = NONE; any in-flight access is discarded (no valid pulse after reset).
- Arbitration each cycle (cycle 0), fixed priority:
  - vga_req=1 → owner=VGA.
  - else aux_req=1 → owner=AUX and aux_gnt=1 combinationally in cycle 0.
  - else owner=NONE.
- Simultaneous vga_req and aux_req: VGA wins. aux_gnt stays 0 and aux must keep aux_req and aux_addr held.
- Address computation:
  - VGA address is vga_y*640 + vga_x, computed as (y<<9)+(y<<7)+x, 19 bits with no overflow.
  - AUX address is aux_addr.
- Out-of-range requests:
  - Condition: vga_x>=H_RES, vga_y>=V_RES, or aux_addr>=H_RES*V_RES.
  - The request still takes its slot and pipeline stage.
  - rom_addr is held at its previous value.
  - The captured data is OOR_COLOR instead of rom_data. aux_err is asserted for AUX requests.
- Pipeline and latency:
  - End of cycle 0: rom_addr and the stage-1 tag {owner, oor} are registered.
  - Cycle 1: rom_data is sampled.
  - End of cycle 1: data is captured into vga_data or aux_data per tag, and the matching valid is set.
  - Visible in cycle 2. Latency is exactly 2 cycles; throughput is 1 access per cycle.
- Output holding: vga_data and aux_data hold their last value between valids. Valids are single-cycle pulses.
- Back-to-back aux: if aux_req is still 1 in the cycle after aux_gnt, that is a new request. The aux engine must drop aux_req or change aux_addr.
- NONE cycles: rom_addr holds its value and no valid is produced.
- Reset mid-operation: the stage-1 tag is cleared, so valid never fires for pre-reset requests.

Optional Feature:
- Macro: ROM_ARB_STARVE_CNT_EN.
- When defined:
  - Adds output aux_starve_cnt[15:0], a saturating count of cycles with aux_req=1 and aux_gnt=0.
  - Clears on aux_gnt or rst; saturates at 16'hFFFF.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared header rom_arb_defs.vh holds:
  - H_RES/V_RES defaults.
  - PIX_COUNT = 307200.
  - Owner encodings OWN_NONE=2'd0, OWN_VGA=2'd1, OWN_AUX=2'd2.
- One sub-module, pixel_addr_calc: combinational (x, y) → {addr, oor}. This is reused by the future sprite ROM.

Test Plan:
- Reset then vga_req=1, x=0, y=0 with ROM[0]=12'hABC → rom_addr=0 in cycle 1; vga_valid=1 and vga_data=12'hABC in cycle 2; all outputs 0 during rst.
- vga x=639, y=479 → rom_addr=307199, vga_valid 2 cycles later. x=640, y=10 → vga_data=12'h000 and rom_addr unchanged.
- vga_req and aux_req=1 (addr=100) together for 3 cycles, then vga_req drops → aux_gnt in cycle 3 only; aux_valid in cycle 5 with ROM[100]. With ROM_ARB_STARVE_CNT_EN, aux_starve_cnt reads 3 before gnt and 0 after.
- aux_addr=307200 → aux_gnt, then aux_valid+aux_err with aux_data=12'h000 two cycles later.
- Continuous vga_req with x incrementing 0..9 → 10 consecutive vga_valid pulses, data equal to ROM[0..9] in order.
- Assert rst in the cycle after a vga grant → no vga_valid afterwards; outputs are 0 in the cycle after rst.
